// File: rtl/rect_fill_if.sv
// Start/plot bundle between the drawing-control FSMs, rect_fill_engine and the VGA adapter.
// RECT_FILL_OUTLINE_EN adds the 'outline' request bit.
interface rect_fill_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int SIZE_W  = 5,
  parameter int COLOR_W = 3
) ();
  logic               start;
  logic [X_W-1:0]     x_in;
  logic [Y_W-1:0]     y_in;
  logic [SIZE_W-1:0]  w_in;
  logic [SIZE_W-1:0]  h_in;
  logic [COLOR_W-1:0] color_in;
`ifdef RECT_FILL_OUTLINE_EN
  logic               outline;
`endif
  logic               plot_ready;
  logic               busy;
  logic               done;
  logic [X_W-1:0]     vga_x;
  logic [Y_W-1:0]     vga_y;
  logic [COLOR_W-1:0] vga_color;
  logic               plot;

  modport master (
`ifdef RECT_FILL_OUTLINE_EN
    output outline,
`endif
    output start, x_in, y_in, w_in, h_in, color_in, plot_ready,
    input  busy, done, vga_x, vga_y, vga_color, plot
  );

  modport slave (
`ifdef RECT_FILL_OUTLINE_EN
    input  outline,
`endif
    input  start, x_in, y_in, w_in, h_in, color_in, plot_ready,
    output busy, done, vga_x, vga_y, vga_color, plot
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle rasteriser: walks w x h pixels in raster order, clipping off-screen ones.
// RECT_FILL_OUTLINE_EN enables perimeter-only drawing via the latched 'outline' bit.
module rect_fill_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SIZE_W   = 5,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic        clk,
  input logic        resetn,
  rect_fill_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [X_W:0]      SW  = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]      SH  = (Y_W+1)'(SCREEN_H);
  localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

  state_t             state, state_n;
  logic [X_W-1:0]     xr, x_cur;
  logic [Y_W-1:0]     yr, y_cur;
  logic [SIZE_W-1:0]  wr, hr, cx, cy, cx_n, cy_n;
  logic [COLOR_W-1:0] cr, c_cur;
  logic [X_W:0]       px;
  logic [Y_W:0]       py;
  logic               lat, vis, last, skip;
`ifdef RECT_FILL_OUTLINE_EN
  logic               olr;
`endif

  assign lat = (state == IDLE) && bus.start;

  // Interior rows of an outline only visit their first and last column.
`ifdef RECT_FILL_OUTLINE_EN
  assign skip = olr && (cy != '0) && (cy != hr - ONE);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    last    = (cx == wr - ONE) && (cy == hr - ONE);
    case (state)
      IDLE: if (bus.start) begin
        cx_n    = '0;
        cy_n    = '0;
        state_n = (bus.w_in == '0 || bus.h_in == '0) ? DONE : DRAW;
      end
      DRAW: if (!bus.plot || bus.plot_ready) begin
        if (last)                  state_n = DONE;
        else if (cx == wr - ONE) begin
          cx_n = '0;
          cy_n = cy + ONE;
        end
        else if (skip && cx == '0) cx_n = wr - ONE;
        else                       cx_n = cx + ONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next pixel so the first plot lands one cycle after start.
  always_comb begin
    x_cur = lat ? bus.x_in     : xr;
    y_cur = lat ? bus.y_in     : yr;
    c_cur = lat ? bus.color_in : cr;
    px    = {1'b0, x_cur} + (X_W+1)'(cx_n);
    py    = {1'b0, y_cur} + (Y_W+1)'(cy_n);
    vis   = (px < SW) && (py < SH);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      cx            <= '0;
      cy            <= '0;
      xr            <= '0;
      yr            <= '0;
      wr            <= '0;
      hr            <= '0;
      cr            <= '0;
`ifdef RECT_FILL_OUTLINE_EN
      olr           <= 1'b0;
`endif
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.plot      <= 1'b0;
      bus.vga_x     <= '0;
      bus.vga_y     <= '0;
      bus.vga_color <= '0;
    end else begin
      state <= state_n;
      cx    <= cx_n;
      cy    <= cy_n;
      if (lat) begin
        xr  <= bus.x_in;
        yr  <= bus.y_in;
        wr  <= bus.w_in;
        hr  <= bus.h_in;
        cr  <= bus.color_in;
`ifdef RECT_FILL_OUTLINE_EN
        olr <= bus.outline;
`endif
      end
      bus.busy <= (state_n != IDLE);
      bus.done <= (state_n == DONE);
      bus.plot <= (state_n == DRAW) && vis;
      if (state_n == DRAW) begin
        bus.vga_x     <= px[X_W-1:0];
        bus.vga_y     <= py[Y_W-1:0];
        bus.vga_color <= c_cur;
      end
    end
  end
endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: expected pixels queued at start, monitor checks accepted plots.
module tb_rect_fill_engine;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rect_fill_if bus ();
  rect_fill_engine dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  pix_t exp_q[$];
  pix_t mon_e;
  int tests = 0, fails = 0, acc = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted pixel must be the next expected one.
  always @(negedge clk) if (resetn) begin
    if (bus.plot && bus.plot_ready) begin
      acc++;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_plot: got (%0d,%0d) required none", bus.vga_x, bus.vga_y);
      end else begin
        mon_e = exp_q.pop_front();
        chk("plot_x", 32'(bus.vga_x), 32'(mon_e.x));
        chk("plot_y", 32'(bus.vga_y), 32'(mon_e.y));
        chk("plot_color", 32'(bus.vga_color), 32'(mon_e.c));
      end
    end
    if (bus.done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input int x, input int y, input int c);
    exp_q.push_back(pix_t'{8'(x), 7'(y), 3'(c)});
  endtask

  task automatic start_rect(input int x, input int y, input int w, input int h, input int c, input bit ol);
    bus.x_in = 8'(x); bus.y_in = 7'(y); bus.w_in = 5'(w); bus.h_in = 5'(h); bus.color_in = 3'(c);
`ifdef RECT_FILL_OUTLINE_EN
    bus.outline = ol;
`else
    if (ol) $display("outline request ignored in solid-fill build");
`endif
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  // n = cycle index (busy-rise cycle is 1) on which done is seen.
  task automatic wait_done(input bit toggle, output int n);
    n = 1;
    while (!bus.done && n < 3000) begin
      if (toggle) bus.plot_ready = ~bus.plot_ready;
      cyc();
      n++;
    end
    if (!bus.done) chk("done_timeout", 32'(bus.done), 1);
  endtask

  int n, a0, d0, k;

  initial begin
    resetn = 1'b0; bus.start = 1'b0; bus.plot_ready = 1'b0;
    bus.x_in = '0; bus.y_in = '0; bus.w_in = '0; bus.h_in = '0; bus.color_in = '0;
`ifdef RECT_FILL_OUTLINE_EN
    bus.outline = 1'b0;
`endif
    cyc(); cyc();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_plot", 32'(bus.plot), 0);
    chk("rst_vga_x", 32'(bus.vga_x), 0);
    chk("rst_vga_y", 32'(bus.vga_y), 0);
    chk("rst_color", 32'(bus.vga_color), 0);
    resetn = 1'b1;
    cyc();

    // 4x4 at (10,20), ready held high
    bus.plot_ready = 1'b1;
    for (int r = 0; r < 4; r++) for (int q = 0; q < 4; q++) push(10 + q, 20 + r, 5);
    a0 = acc; d0 = done_cnt;
    start_rect(10, 20, 4, 4, 5, 1'b0);
    chk("t1_busy_rise", 32'(bus.busy), 1);
    chk("t1_first_plot", 32'(bus.plot), 1);
    wait_done(1'b0, n);
    chk("t1_done_cycle", 32'(n), 17);
    cyc();
    chk("t1_done_pulses", 32'(done_cnt - d0), 1);
    chk("t1_done_low", 32'(bus.done), 0);
    chk("t1_idle_busy", 32'(bus.busy), 0);
    chk("t1_plots", 32'(acc - a0), 16);
    chk("t1_queue_empty", 32'(exp_q.size()), 0);

    // Same rectangle with ready toggling
    for (int r = 0; r < 4; r++) for (int q = 0; q < 4; q++) push(10 + q, 20 + r, 5);
    a0 = acc; d0 = done_cnt;
    start_rect(10, 20, 4, 4, 5, 1'b0);
    wait_done(1'b1, n);
    cyc();
    bus.plot_ready = 1'b1;
    chk("t2_plots", 32'(acc - a0), 16);
    chk("t2_done_pulses", 32'(done_cnt - d0), 1);
    chk("t2_queue_empty", 32'(exp_q.size()), 0);

    // Clipping at bottom-right corner
    push(158, 118, 2); push(159, 118, 2); push(158, 119, 2); push(159, 119, 2);
    a0 = acc;
    start_rect(158, 118, 4, 3, 2, 1'b0);
    wait_done(1'b0, n);
    chk("t3_done_cycle", 32'(n), 13);
    cyc();
    chk("t3_plots", 32'(acc - a0), 4);
    chk("t3_queue_empty", 32'(exp_q.size()), 0);

    // Zero width: straight to DONE
    a0 = acc; d0 = done_cnt;
    start_rect(30, 30, 0, 7, 1, 1'b0);
    chk("t4_busy", 32'(bus.busy), 1);
    chk("t4_done", 32'(bus.done), 1);
    chk("t4_plot", 32'(bus.plot), 0);
    cyc();
    chk("t4_busy_fall", 32'(bus.busy), 0);
    chk("t4_done_fall", 32'(bus.done), 0);
    chk("t4_plots", 32'(acc - a0), 0);
    chk("t4_done_pulses", 32'(done_cnt - d0), 1);

    // Reset after the 5th plot of a 31x31
    for (int q = 0; q < 5; q++) push(q, 0, 7);
    a0 = acc; d0 = done_cnt; k = 0;
    start_rect(0, 0, 31, 31, 7, 1'b0);
    while (acc - a0 < 5 && k < 100) begin cyc(); k++; end
    chk("t5_five_plots", 32'(acc - a0), 5);
    bus.plot_ready = 1'b0;
    resetn = 1'b0;
    cyc();
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_done", 32'(bus.done), 0);
    chk("t5_plot", 32'(bus.plot), 0);
    chk("t5_vga_x", 32'(bus.vga_x), 0);
    chk("t5_vga_y", 32'(bus.vga_y), 0);
    chk("t5_color", 32'(bus.vga_color), 0);
    resetn = 1'b1;
    bus.plot_ready = 1'b1;
    cyc();
    chk("t5_idle", 32'(bus.busy), 0);
    chk("t5_no_done", 32'(done_cnt - d0), 0);
    push(0, 0, 6); push(1, 0, 6); push(0, 1, 6); push(1, 1, 6);
    a0 = acc;
    start_rect(0, 0, 2, 2, 6, 1'b0);
    wait_done(1'b0, n);
    chk("t5b_done_cycle", 32'(n), 5);
    cyc();
    chk("t5b_plots", 32'(acc - a0), 4);
    chk("t5b_queue_empty", 32'(exp_q.size()), 0);

`ifdef RECT_FILL_OUTLINE_EN
    // Outline 5x4 at origin: perimeter only
    for (int r = 0; r < 4; r++) for (int q = 0; q < 5; q++)
      if (r == 0 || r == 3 || q == 0 || q == 4) push(q, r, 3);
    a0 = acc;
    start_rect(0, 0, 5, 4, 3, 1'b1);
    wait_done(1'b0, n);
    chk("t6_done_cycle", 32'(n), 15);
    cyc();
    chk("t6_plots", 32'(acc - a0), 14);
    chk("t6_queue_empty", 32'(exp_q.size()), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
